// File: rtl/rice_core_wb_stage.sv
// rice core write-back stage: register file commit, two bypassed read ports, retire pulse.
// Optional retired-instruction counter enabled by defining RICE_CORE_INSTRET_EN.
module rice_core_wb_stage #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_enable,
  input  logic            i_stall,
  input  logic            i_ex_valid,
  input  logic [4:0]      i_ex_rd,
  input  logic [XLEN-1:0] i_ex_rd_value,
  input  logic [4:0]      i_rs1,
  input  logic [4:0]      i_rs2,
  output logic [XLEN-1:0] o_rs1_value,
  output logic [XLEN-1:0] o_rs2_value,
  output logic            o_retire,
  input  logic [1:0]      i_instret_we,
  input  logic [31:0]     i_instret_wdata,
  output logic [63:0]     o_instret
);

  logic            commit;
  logic [XLEN-1:0] regs [1:31];

  // A held EX result is consumed only once the stall drops.
  assign commit = i_enable && i_ex_valid && !i_stall;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 1; i < 32; i++) regs[i] <= '0;
    end else if (commit && (i_ex_rd != 5'd0)) begin
      regs[i_ex_rd] <= i_ex_rd_value;
    end
  end

  always_comb begin
    o_rs1_value = '0;
    o_rs2_value = '0;
    if (i_rs1 != 5'd0)
      o_rs1_value = (commit && (i_ex_rd == i_rs1)) ? i_ex_rd_value : regs[i_rs1];
    if (i_rs2 != 5'd0)
      o_rs2_value = (commit && (i_ex_rd == i_rs2)) ? i_ex_rd_value : regs[i_rs2];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) o_retire <= 1'b0;
    else          o_retire <= commit;
  end

`ifdef RICE_CORE_INSTRET_EN
  logic [63:0] instret_q;

  // CSR writes take priority over the increment in the same cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      instret_q <= '0;
    end else if (i_instret_we != 2'b00) begin
      if (i_instret_we[0]) instret_q[31:0]  <= i_instret_wdata;
      if (i_instret_we[1]) instret_q[63:32] <= i_instret_wdata;
    end else if (commit) begin
      instret_q <= instret_q + 64'd1;
    end
  end

  assign o_instret = instret_q;
`else
  logic unused_instret;
  assign unused_instret = ^{i_instret_we, i_instret_wdata};
  assign o_instret = '0;
`endif

endmodule

// File: tb/tb_rice_core_wb_stage.sv
// Randomized self-checking bench for rice_core_wb_stage against a register-file/counter model.
module tb_rice_core_wb_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0, stall = 1'b0, ex_valid = 1'b0;
  logic [4:0]  ex_rd = '0, rs1 = '0, rs2 = '0;
  logic [31:0] ex_val = '0, rs1_val, rs2_val, ic_wdata = '0;
  logic [1:0]  ic_we = '0;
  logic        retire;
  logic [63:0] instret;

  int n_cmp = 0, n_err = 0;

  logic [31:0] m_rf [0:31];
  logic        m_ret;
  logic [63:0] m_cnt;

  rice_core_wb_stage #(.XLEN(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(en), .i_stall(stall),
    .i_ex_valid(ex_valid), .i_ex_rd(ex_rd), .i_ex_rd_value(ex_val),
    .i_rs1(rs1), .i_rs2(rs2), .o_rs1_value(rs1_val), .o_rs2_value(rs2_val),
    .o_retire(retire), .i_instret_we(ic_we), .i_instret_wdata(ic_wdata),
    .o_instret(instret)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] exp_cnt();
`ifdef RICE_CORE_INSTRET_EN
    return m_cnt;
`else
    return 64'd0;
`endif
  endfunction

  function automatic logic [31:0] exp_read(input logic [4:0] a, input bit c,
                                           input logic [4:0] rd, input logic [31:0] v);
    if (a == 0) return 32'd0;
    if (c && rd == a) return v;
    return m_rf[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    m_ret = 1'b0;
    m_cnt = '0;
  endtask

  task automatic cyc(input bit e, input bit v, input bit s, input logic [4:0] rd,
                     input logic [31:0] val, input logic [4:0] a1, input logic [4:0] a2,
                     input logic [1:0] we, input logic [31:0] wd);
    bit c;
    @(negedge clk);
    en = e; ex_valid = v; stall = s; ex_rd = rd; ex_val = val;
    rs1 = a1; rs2 = a2; ic_we = we; ic_wdata = wd;
    #1;
    c = e && v && !s;
    chk("rs1", {32'd0, rs1_val}, {32'd0, exp_read(a1, c, rd, val)});
    chk("rs2", {32'd0, rs2_val}, {32'd0, exp_read(a2, c, rd, val)});
    @(posedge clk);
    #1;
    if (c && rd != 0) m_rf[rd] = val;
    m_ret = c;
    if (we != 2'b00) begin
      if (we[0]) m_cnt[31:0]  = wd;
      if (we[1]) m_cnt[63:32] = wd;
    end else if (c) begin
      m_cnt = m_cnt + 64'd1;
    end
    chk("retire", {63'd0, retire}, {63'd0, m_ret});
    chk("instret", instret, exp_cnt());
  endtask

  initial begin
    bit e, v, s;
    logic [4:0] rd, a1, a2;
    logic [1:0] we;
    model_reset();

    // Reset state: sweep all read addresses while reset is held
    #2;
    for (int i = 0; i < 32; i++) begin
      rs1 = 5'(i); rs2 = 5'(31 - i);
      #1;
      chk("rst_rs1", {32'd0, rs1_val}, 64'd0);
      chk("rst_rs2", {32'd0, rs2_val}, 64'd0);
    end
    chk("rst_retire", {63'd0, retire}, 64'd0);
    chk("rst_instret", instret, 64'd0);
    @(negedge clk); rst_n = 1'b1;

    // Bypass to both ports, then storage
    cyc(1, 1, 0, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5, 2'b00, 0);
    cyc(1, 0, 0, 5'd0, 32'h0, 5'd5, 5'd5, 2'b00, 0);
    // rd = 0 retires without a write
    cyc(1, 1, 0, 5'd0, 32'h1234, 5'd0, 5'd0, 2'b00, 0);
    // Held instruction across a 3-cycle stall with changing data
    cyc(1, 1, 1, 5'd7, 32'h1111_0000, 5'd7, 5'd5, 2'b00, 0);
    cyc(1, 1, 1, 5'd7, 32'h2222_0000, 5'd7, 5'd7, 2'b00, 0);
    cyc(1, 1, 1, 5'd7, 32'h3333_0000, 5'd7, 5'd7, 2'b00, 0);
    cyc(1, 1, 0, 5'd7, 32'h4444_0000, 5'd7, 5'd7, 2'b00, 0);
    cyc(1, 0, 0, 5'd7, 32'h5555_0000, 5'd7, 5'd7, 2'b00, 0);
    // Enable low blocks commit, counter write still honoured
    cyc(0, 1, 0, 5'd9, 32'hBAD0_BAD0, 5'd9, 5'd9, 2'b00, 0);
    cyc(0, 1, 0, 5'd9, 32'hBAD0_BAD1, 5'd9, 5'd5, 2'b10, 32'h0000_00AB);
    // Counter wrap
    cyc(1, 0, 0, 5'd0, 32'h0, 5'd0, 5'd0, 2'b11, 32'hFFFF_FFFF);
    cyc(1, 1, 0, 5'd3, 32'h0000_0003, 5'd3, 5'd0, 2'b00, 0);
    // Write wins over commit, high word untouched
    cyc(1, 0, 0, 5'd0, 32'h0, 5'd0, 5'd0, 2'b10, 32'h0000_ABCD);
    cyc(1, 1, 0, 5'd4, 32'h0000_0044, 5'd4, 5'd3, 2'b01, 32'h0000_0010);
    // Back-to-back commits to the same rd
    cyc(1, 1, 0, 5'd6, 32'hAAAA_0001, 5'd6, 5'd6, 2'b00, 0);
    cyc(1, 1, 0, 5'd6, 32'hAAAA_0002, 5'd6, 5'd6, 2'b00, 0);
    cyc(1, 0, 0, 5'd6, 32'h0, 5'd6, 5'd0, 2'b00, 0);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      e  = ($urandom_range(0, 9) != 0);
      v  = ($urandom_range(0, 9) < 7);
      s  = ($urandom_range(0, 3) == 0);
      rd = 5'($urandom_range(0, 31));
      a1 = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31));
      we = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      cyc(e, v, s, rd, $urandom, a1, a2, we, $urandom);
    end

    // Reset asserted mid-stall clears everything immediately
    cyc(1, 1, 0, 5'd12, 32'h0C0C_0C0C, 5'd12, 5'd0, 2'b00, 0);
    @(negedge clk);
    en = 1; ex_valid = 1; stall = 1; ex_rd = 5'd12; ex_val = 32'h7777_7777;
    rs1 = 5'd12; rs2 = 5'd5; ic_we = 2'b00;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_rs1", {32'd0, rs1_val}, 64'd0);
    chk("async_rs2", {32'd0, rs2_val}, 64'd0);
    chk("async_retire", {63'd0, retire}, 64'd0);
    chk("async_instret", instret, 64'd0);
    @(negedge clk); stall = 0; ex_valid = 0;
    @(negedge clk); rst_n = 1'b1;
    cyc(1, 0, 0, 5'd0, 32'h0, 5'd12, 5'd5, 2'b00, 0);
    cyc(1, 1, 0, 5'd12, 32'h1357_9BDF, 5'd12, 5'd12, 2'b00, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
